// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared definitions for the RV32M multiply/divide sequencer:
//               operation encodings (RV32M funct3), FSM state encoding,
//               datapath width, special result constants and small helpers
//               for sign detection and magnitude extraction.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] SIGNED_MIN = 32'h8000_0000;

  // RV32M funct3 encodings
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Two's-complement sign bit test
  function automatic logic is_neg(input logic [XLEN-1:0] v);
    return (v & SIGNED_MIN) != '0;
  endfunction

  // Magnitude of v when it is to be treated as a negative signed value
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_if
// Description : EX-stage handshake bundle between the pipeline and the
//               multiply/divide sequencer.
//               master (pipeline) drives : start, op, a, b, flush
//               slave  (sequencer) drives: busy, stall, done, result
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_if;
  import muldiv_pkg::*;

  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, a, b, flush,
    input  busy, stall, done, result
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, stall, done, result
  );

endinterface
`default_nettype wire

// File: rtl/muldiv_dp.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_dp
// Description : Shared multiply/divide datapath. Holds the 64-bit
//               product/remainder:quotient register, the 32-bit
//               multiplicand/divisor register and one 33-bit add/sub that
//               serves the shift-add multiply step, the restoring-divide
//               trial subtract and the final two's-complement negate.
// Ports       : clk, rst_n   - clock, async active-low reset
//               i_load       - capture op and operand magnitudes
//               i_step       - perform one iteration
//               i_fix        - route the adder to the sign-correction negate
//               i_op/i_a/i_b - operation and raw operands (used on i_load)
//               o_fix_val    - final, sign-corrected result (valid in FIX)
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_dp
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_fix,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_fix_val
);

  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2:0]        op_q, op_d;
  logic              res_neg_q, res_neg_d;
  logic              dz_q, dz_d;

  logic              w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic              w_is_div, w_sel_hi, w_fix_cin, w_dz_sel;
  logic [XLEN-1:0]   w_sel;
  logic [XLEN:0]     w_opa, w_opb;
  logic              w_cin;
  logic [XLEN+1:0]   w_sum;

  // Operand signedness of the incoming op
  always_comb begin
    w_a_sgn = (i_op == OP_MULH) || (i_op == OP_MULHSU) ||
              (i_op == OP_DIV)  || (i_op == OP_REM);
    w_b_sgn = (i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM);
    w_a_neg = w_a_sgn & is_neg(i_a);
    w_b_neg = w_b_sgn & is_neg(i_b);
  end

  // Result selection for the latched op
  always_comb begin
    w_is_div = op_q[2];
    // MUL and DIV/DIVU take the low word; MULH* and REM* the high word
    w_sel_hi = op_q[2] ? op_q[1] : (op_q[1:0] != 2'b00);
    w_sel    = w_sel_hi ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
    // Negating only the high word of a 64-bit product: the +1 carries into
    // the high word only when the low word is all zeros.
    w_fix_cin = w_is_div ? 1'b1 : ~|prod_q[XLEN-1:0];
    w_dz_sel  = op_q[2] & ~op_q[1] & dz_q;
  end

  // The single shared adder
  always_comb begin
    w_opa = '0;
    w_opb = '0;
    w_cin = 1'b0;
    if (i_fix) begin
      w_opa = '0;
      w_opb = ~{1'b0, w_sel};
      w_cin = w_fix_cin;
    end else if (w_is_div) begin
      // Shifted partial remainder (33 bits) minus divisor
      w_opa = prod_q[2*XLEN-1:XLEN-1];
      w_opb = ~{1'b0, mcand_q};
      w_cin = 1'b1;
    end else begin
      w_opa = {1'b0, prod_q[2*XLEN-1:XLEN]};
      w_opb = {1'b0, mcand_q};
      w_cin = 1'b0;
    end
    w_sum = {1'b0, w_opa} + {1'b0, w_opb} + {{(XLEN+1){1'b0}}, w_cin};
  end

  // Register next-state
  always_comb begin
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    op_d      = op_q;
    res_neg_d = res_neg_q;
    dz_d      = dz_q;
    if (i_load) begin
      op_d      = i_op;
      prod_d    = {{XLEN{1'b0}}, mag(i_a, w_a_neg)};
      mcand_d   = mag(i_b, w_b_neg);
      // REM* sign follows the dividend; DIV/MULH follow a^b; MULHSU follows a
      res_neg_d = (i_op[2] & i_op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
      dz_d      = (i_b == '0);
    end else if (i_step) begin
      if (w_is_div) begin
        // Carry out set means no borrow: keep difference, quotient bit = 1
        if (w_sum[XLEN+1]) begin
          prod_d = {w_sum[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
        end else begin
          prod_d = {prod_q[2*XLEN-2:0], 1'b0};
        end
      end else begin
        if (prod_q[0]) begin
          prod_d = {w_sum[XLEN:0], prod_q[XLEN-1:1]};
        end else begin
          prod_d = {1'b0, prod_q[2*XLEN-1:1]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q    <= '0;
      mcand_q   <= '0;
      op_q      <= '0;
      res_neg_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      prod_q    <= prod_d;
      mcand_q   <= mcand_d;
      op_q      <= op_d;
      res_neg_q <= res_neg_d;
      dz_q      <= dz_d;
    end
  end

  // Divide-by-zero quotient is forced; the remainder already equals a
  always_comb begin
    if (w_dz_sel) begin
      o_fix_val = DIV_ZERO_Q;
    end else if (res_neg_q) begin
      o_fix_val = w_sum[XLEN-1:0];
    end else begin
      o_fix_val = w_sel;
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq
// Description : Iterative RV32M multiply/divide sequencer (EX stage).
//               IDLE -> CALC (32 steps) -> FIX -> DONE; one op at a time.
//               Optional macro MULDIV_EARLY_OUT_EN: zero-operand multiplies
//               and divides by zero bypass CALC/FIX and finish next cycle.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - muldiv_if.slave: start/op/a/b/flush in,
//                        busy/stall/done/result out
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
)(
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  if (XLEN != 32) begin : g_xlen_check
    $error("muldiv_seq: only XLEN=32 is supported");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              w_accept;
  logic              w_load, w_step, w_fix;
  logic [XLEN-1:0]   w_fix_val;
  logic              w_early;
  logic [XLEN-1:0]   w_early_val;

  assign w_accept = bus.start & ~bus.flush;

`ifdef MULDIV_EARLY_OUT_EN
  assign w_early     = bus.op[2] ? (bus.b == '0) : ((bus.a == '0) | (bus.b == '0));
  assign w_early_val = bus.op[2] ? (bus.op[1] ? bus.a : DIV_ZERO_Q) : '0;
`else
  assign w_early     = 1'b0;
  assign w_early_val = '0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_fix    = (state_q == ST_FIX);
    unique case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          cnt_d = '0;
          if (w_early) begin
            result_d = w_early_val;
            state_d  = ST_DONE;
          end else begin
            w_load  = 1'b1;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          w_step = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            state_d = ST_FIX;
          end
        end
      end
      ST_FIX: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          result_d = w_fix_val;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        // done completes even under flush; a start here is not taken
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  muldiv_dp u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_fix     (w_fix),
    .i_op      (bus.op),
    .i_a       (bus.a),
    .i_b       (bus.b),
    .o_fix_val (w_fix_val)
  );

  assign bus.busy   = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign bus.stall  = ((state_q == ST_IDLE) & w_accept) | bus.busy;
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_seq
// Description : Directed self-checking bench for muldiv_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  muldiv_if bus ();

  muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef MULDIV_EARLY_OUT_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 34;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch one op and check latency, result, busy window and done width
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    int k;
    int got_lat;
    logic [31:0] got_res;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    #1 check_val({tag, "_stall_req"}, 64'(bus.stall), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    got_lat = 0;
    got_res = '0;
    k = 1;
    while (k <= 40 && got_lat == 0) begin
      if (bus.done) begin
        got_lat = k;
        got_res = bus.result;
      end else if (lat == 34 && (k == 1 || k == 33)) begin
        check_val($sformatf("%s_busy_k%0d", tag, k), 64'(bus.busy), 64'd1);
      end
      if (got_lat == 0) begin
        @(negedge clk);
        k++;
      end
    end
    check_val({tag, "_latency"}, 64'(got_lat), 64'(lat));
    check_val({tag, "_result"}, 64'(got_res), 64'(exp));
    if (got_lat != 0) begin
      @(negedge clk);
      check_val({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
      check_val({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
      check_val({tag, "_result_hold"}, 64'(bus.result), 64'(exp));
    end
  endtask

  initial begin
    int ndone;
    int dcnt;
    int dt [3];
    logic [31:0] dr [3];

    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst_busy",   64'(bus.busy),   64'd0);
    check_val("rst_done",   64'(bus.done),   64'd0);
    check_val("rst_stall",  64'(bus.stall),  64'd0);
    check_val("rst_result", 64'(bus.result), 64'd0);
    rst_n = 1'b1;

    // Multiply family
    run_op("mul_7xm3",     OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op("mul_ovf",      OP_MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 34);
    run_op("mulhu_max",    OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("mulh_m1m1",    OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
    run_op("mulhsu_m1x2",  OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34);
    run_op("mulh_m7x3",    OP_MULH,   32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 34);
    run_op("mulh_min2",    OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run_op("mulh_m2xmin",  OP_MULH,   32'hFFFF_FFFE, 32'h8000_0000, 32'h0000_0001, 34);
    run_op("mulh_lo_zero", OP_MULH,   32'hFFFF_0000, 32'h0001_0000, 32'hFFFF_FFFF, 34);

    // Divide family
    run_op("div_m7_2",     OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    run_op("rem_m7_2",     OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    run_op("divu_100_7",   OP_DIVU,   32'd100,       32'd7,         32'd14,        34);
    run_op("remu_100_7",   OP_REMU,   32'd100,       32'd7,         32'd2,         34);
    run_op("divu_by0",     OP_DIVU,   32'h0000_1234, 32'd0,         32'hFFFF_FFFF, ZLAT);
    run_op("remu_by0",     OP_REMU,   32'h0000_1234, 32'd0,         32'h0000_1234, ZLAT);
    run_op("div_m7_by0",   OP_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, ZLAT);
    run_op("rem_m7_by0",   OP_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, ZLAT);
    run_op("div_ovf",      OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
    run_op("rem_ovf",      OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34);

    // Flush at N+10: op dropped, no done
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MUL; bus.a = 32'd5; bus.b = 32'd6;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 10) bus.flush = 1'b1;
      if (k == 11) begin
        bus.flush = 1'b0;
        check_val("flush_busy_low", 64'(bus.busy), 64'd0);
      end
      if (bus.done) ndone++;
      @(negedge clk);
    end
    check_val("flush_no_done", 64'(ndone), 64'd0);
    run_op("after_flush", OP_MUL, 32'd5, 32'd6, 32'd30, 34);

    // Reset mid-operation
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy",   64'(bus.busy),   64'd0);
    check_val("midrst_done",   64'(bus.done),   64'd0);
    check_val("midrst_result", 64'(bus.result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) ndone++;
      @(negedge clk);
    end
    check_val("midrst_no_done", 64'(ndone), 64'd0);
    run_op("after_rst", OP_REMU, 32'd100, 32'd7, 32'd2, 34);

    // start held high: one op per 35 cycles
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MUL; bus.a = 32'd3; bus.b = 32'd5;
    @(posedge clk);
    @(negedge clk);
    dcnt = 0;
    for (int i = 0; i < 3; i++) begin
      dt[i] = 0;
      dr[i] = '0;
    end
    for (int k = 1; k <= 110; k++) begin
      if (bus.done && dcnt < 3) begin
        dt[dcnt] = k;
        dr[dcnt] = bus.result;
        dcnt++;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check_val("b2b_count", 64'(dcnt),  64'd3);
    check_val("b2b_t0",    64'(dt[0]), 64'd34);
    check_val("b2b_t1",    64'(dt[1]), 64'd69);
    check_val("b2b_t2",    64'(dt[2]), 64'd104);
    check_val("b2b_r0",    64'(dr[0]), 64'd15);
    check_val("b2b_r2",    64'(dr[2]), 64'd15);
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative RV32M multiply/divide sequencer in the EX stage, beside the single-cycle ALU. Accepts one M-extension op at a time and runs a radix-2 shift-add multiply or restoring divide over 32 cycles on one shared 33-bit add/sub datapath. Raises a pipeline stall while busy and delivers a one-cycle done/result to the EX/MEM register.

Parameters:
XLEN, 32, operand/result width; only 32 supported, any other value is a elaboration error
CNT_W, 6, iteration counter width, holds 0..XLEN

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  launch op; sampled only in IDLE
op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  in  32  rs1 operand, captured on accepted start
b  in  32  rs2 operand, captured on accepted start
flush  in  1  abort current op (branch/exception kill)
busy  out  1  high in CALC and FIX
stall  out  1  (IDLE & start & ~flush) | CALC | FIX
done  out  1  one-cycle pulse, result valid
result  out  32  valid only while done=1; holds last value otherwise

Behaviour:
- Clock and reset: single clock clk; rst_n asynchronous, active-low. Reset forces state=IDLE, busy=0, done=0, result=0, counter=0, all datapath registers=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE: start & ~flush -> latch op, magnitudes |a| and |b| per signedness (MULH/DIV/REM: both signed; MULHSU: a signed, b unsigned; others unsigned), and result-sign flags. Counter=0. Next state CALC.
- CALC: one bit per cycle. Multiply: if multiplier LSB, add multiplicand to upper product half; shift the 64-bit product right. Divide: shift {rem,quot} left, trial-subtract divisor, and on no borrow keep the difference and set the quotient bit. Counter increments; leaves to FIX after the 32nd step (counter==31).
- FIX: apply sign correction (two's-complement negate on the same adder) and select the output.
  - MUL: low 32 bits.
  - MULH/MULHSU/MULHU: high 32 bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder. Remainder sign follows the dividend.
  - Divide by zero: quotient 0xFFFFFFFF, remainder = a (unmodified).
  - Signed overflow 0x80000000 / -1: quotient 0x80000000, remainder 0.
  - Register result; next state DONE.
- DONE: done=1 for exactly one cycle, stall=0 so the pipeline advances; next state IDLE. A start in DONE is ignored; it must be re-presented in IDLE.
- Latency: start sampled at edge N, done high in cycle N+34 (32 CALC + 1 FIX + 1 DONE). Throughput: one op per 35 cycles.
- start while not IDLE: ignored, with no effect on the running op.
- flush: in CALC/FIX, next state IDLE, busy=0, and done never asserted for the aborted op. In DONE, done still completes this cycle (the EX/MEM register discards it). In IDLE with start, the op is not accepted.
- Reset mid-operation: immediate return to IDLE, no done.
- Overflow in the product is discarded; the 64-bit product is always exact before selection.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: in IDLE, b==0 on DIV*/REM*, or a==0 or b==0 on MUL*, skips CALC/FIX. Result is computed directly (div-by-zero values above, or 0 for multiply), state goes straight to DONE, and done arrives at N+1. stall is only the IDLE start term.
- Undefined: every op takes the full 34-cycle path with identical results.

Decomposition:
- Package muldiv_pkg: op encodings (OP_MUL..OP_REMU), state encodings, XLEN, DIV_ZERO_Q=32'hFFFFFFFF, SIGNED_MIN=32'h80000000.
- One sub-module, muldiv_dp: 64-bit product/remainder register, 32-bit multiplicand/divisor register, single 33-bit add/sub, and negate mux. It takes step/load/fix controls from the muldiv_seq FSM.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) -> done at N+34, result=0xFFFFFFEB; busy high N+1..N+33.
- MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
- DIVU a=0x1234, b=0 -> 0xFFFFFFFF; REMU -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- Start MUL, assert flush at N+10 -> busy=0 at N+11, no done through N+40. Next start then completes normally. rst_n low at N+5 -> immediate IDLE, outputs 0.
- start held high continuously -> ops back-to-back every 35 cycles. With MULDIV_EARLY_OUT_EN, DIV by 0 -> done at N+1 with 0xFFFFFFFF.
